// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // ceil(width * log10(2)) using a fixed-point log10(2) ~= 0.30103.
  // width*log10(2) is never an integer for width > 0, so this is the digit
  // count of 2^width - 1.
  function automatic int unsigned bcd_min_digits(input int unsigned width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational double-dabble digit correction: add 3 to a digit that is 5 or more.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= BCD_ADJ_THRESH) ? digit + BCD_ADJ_ADD : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one operand bit per clock.
// Build option: define BIN_TO_BCD_SIGNED_EN to treat bin as two's complement.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic                  ovf
);

  localparam int unsigned ACC_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state, state_next;

  logic [BIN_W-1:0] operand;
  logic [BIN_W-1:0] magnitude;
  logic             neg_sel;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_adj;
  logic [CNT_W-1:0] cnt;
  logic             accept;

`ifdef BIN_TO_BCD_SIGNED_EN
  // '0 - bin maps -2^(BIN_W-1) onto itself, which read unsigned is the magnitude.
  assign magnitude = bin[BIN_W-1] ? ('0 - bin) : bin;
  assign neg_sel   = bin[BIN_W-1];
`else
  assign magnitude = bin;
  assign neg_sel   = 1'b0;
`endif

  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (acc[4*d +: 4]),
      .adjusted (acc_adj[4*d +: 4])
    );
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CNT_LAST) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      operand   <= '0;
      acc       <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
      if (accept) begin
        operand <= magnitude;
        acc     <= '0;
        cnt     <= '0;
        neg     <= neg_sel;
        ovf     <= 1'b0;
      end else if (state == SHIFT) begin
        // Bit leaving the top digit after correction means the value needs more digits.
        operand <= {operand[BIN_W-2:0], 1'b0};
        acc     <= {acc_adj[ACC_W-2:0], operand[BIN_W-1]};
        cnt     <= cnt + CNT_ONE;
        if (acc_adj[ACC_W-1]) ovf <= 1'b1;
      end
    end
  end

  assign bcd = acc;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq across three parameter sets.
module tb_bin_to_bcd_seq;
  import bcd_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // a: BIN_W=8 DIGITS=3
  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_neg, a_ovf;
  logic [7:0]  a_bin = '0;
  logic [11:0] a_bcd;
  // b: BIN_W=16 DIGITS=5
  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_neg, b_ovf;
  logic [15:0] b_bin = '0;
  logic [19:0] b_bcd;
  // c: BIN_W=8 DIGITS=2
  logic        c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b0, c_neg, c_ovf;
  logic [7:0]  c_bin = '0;
  logic [7:0]  c_bcd;

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .bin(a_bin),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .bcd(a_bcd), .neg(a_neg), .ovf(a_ovf)
  );
  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .bin(b_bin),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .bcd(b_bcd), .neg(b_neg), .ovf(b_ovf)
  );
  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .bin(c_bin),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .bcd(c_bcd), .neg(c_neg), .ovf(c_ovf)
  );

  // One complete conversion on instance a; returns the result and edges from accept to out_valid.
  task automatic a_run(input logic [7:0] v, output logic [11:0] r_bcd, output logic r_neg,
                       output logic r_ovf, output int lat);
    int n;
    n = 0;
    while (a_in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    a_bin = v;
    a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    a_bin = 8'h5A;
    lat = 0;
    while (a_out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    r_bcd = a_bcd;
    r_neg = a_neg;
    r_ovf = a_ovf;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++;
    if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0) $display("FAIL reset_in_ready got a=%b b=%b want 0", a_in_ready, b_in_ready);
    else passed++;
    checks++;
    if (a_out_valid !== 1'b0 || c_out_valid !== 1'b0) $display("FAIL reset_out_valid got a=%b c=%b want 0", a_out_valid, c_out_valid);
    else passed++;
    checks++;
    if (a_bcd !== 12'h000 || a_neg !== 1'b0 || a_ovf !== 1'b0)
      $display("FAIL reset_outputs got bcd=%h neg=%b ovf=%b want 000 0 0", a_bcd, a_neg, a_ovf);
    else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1 || c_in_ready !== 1'b1)
      $display("FAIL release_in_ready got a=%b b=%b c=%b want 1", a_in_ready, b_in_ready, c_in_ready);
    else passed++;
  endtask

  task automatic test_min_digits();
    checks++;
    if (bcd_min_digits(8) !== 3) $display("FAIL min_digits_8 got %0d want 3", bcd_min_digits(8));
    else passed++;
    checks++;
    if (bcd_min_digits(16) !== 5) $display("FAIL min_digits_16 got %0d want 5", bcd_min_digits(16));
    else passed++;
  endtask

  task automatic test_max_8bit();
    logic [11:0] r; logic n_, o_; int lat;
    a_run(8'd255, r, n_, o_, lat);
    checks++;
    if (lat !== 8) $display("FAIL latency_255 got %0d want 8", lat);
    else passed++;
    checks++;
    if (r !== 12'h255 || o_ !== 1'b0) $display("FAIL conv_255 got bcd=%h ovf=%b want 255 0", r, o_);
    else passed++;
    checks++;
    if (a_out_valid !== 1'b0) $display("FAIL retire_255 got out_valid=%b want 0", a_out_valid);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int idx, na, no;
    int acc_at[2];
    int out_at[2];
    logic [11:0] res[2];
    logic hs_in, hs_out;
    logic [11:0] snap;
    idx = 0; na = 0; no = 0;
    a_bin = 8'd0;
    a_in_valid = 1'b1;
    a_out_ready = 1'b1;
    while (no < 2 && idx < 60) begin
      hs_in  = a_in_valid & a_in_ready;
      hs_out = a_out_valid & a_out_ready;
      snap   = a_bcd;
      @(posedge clk); #1;
      if (hs_in && na < 2) begin acc_at[na] = idx; na++; a_bin = 8'd100; end
      if (hs_out) begin out_at[no] = idx; res[no] = snap; no++; end
      idx++;
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b0;
    checks++;
    if (no !== 2 || na !== 2) $display("FAIL b2b_count got accepts=%0d results=%0d want 2 2", na, no);
    else passed++;
    if (no == 2 && na == 2) begin
      checks++;
      if (res[0] !== 12'h000) $display("FAIL b2b_zero got %h want 000", res[0]);
      else passed++;
      checks++;
      if (res[1] !== 12'h100) $display("FAIL b2b_hundred got %h want 100", res[1]);
      else passed++;
      checks++;
      if (out_at[0] - acc_at[0] !== 9) $display("FAIL b2b_retire_edge got %0d want 9", out_at[0] - acc_at[0]);
      else passed++;
      checks++;
      if (acc_at[1] - acc_at[0] !== 10) $display("FAIL b2b_throughput got %0d want 10", acc_at[1] - acc_at[0]);
      else passed++;
    end
  endtask

  task automatic test_hold_16bit();
    int lat;
    bit stable;
    b_bin = 16'hFFFF;
    b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    b_bin = 16'h1234;
    lat = 0;
    while (b_out_valid !== 1'b1 && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat !== 16) $display("FAIL latency_65535 got %0d want 16", lat);
    else passed++;
    checks++;
    if (b_bcd !== 20'h65535 || b_ovf !== 1'b0) $display("FAIL conv_65535 got bcd=%h ovf=%b want 65535 0", b_bcd, b_ovf);
    else passed++;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (b_out_valid !== 1'b1 || b_bcd !== 20'h65535 || b_ovf !== 1'b0) stable = 1'b0;
    end
    checks++;
    if (!stable) $display("FAIL hold_65535 got out_valid=%b bcd=%h want 1 65535", b_out_valid, b_bcd);
    else passed++;
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    checks++;
    if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1)
      $display("FAIL retire_65535 got out_valid=%b in_ready=%b want 0 1", b_out_valid, b_in_ready);
    else passed++;
  endtask

  task automatic test_overflow();
    logic [7:0] vals[2];
    logic [7:0] exp_bcd[2];
    logic       exp_ovf[2];
    int lat;
    vals = '{8'd200, 8'd99};
    exp_bcd = '{8'h00, 8'h99};
    exp_ovf = '{1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      c_bin = vals[i];
      c_in_valid = 1'b1;
      @(posedge clk); #1;
      c_in_valid = 1'b0;
      lat = 0;
      while (c_out_valid !== 1'b1 && lat < 40) begin
        @(posedge clk); #1; lat++;
      end
      checks++;
      if (c_ovf !== exp_ovf[i]) $display("FAIL ovf_%0d got %b want %b", vals[i], c_ovf, exp_ovf[i]);
      else passed++;
      if (!exp_ovf[i]) begin
        checks++;
        if (c_bcd !== exp_bcd[i]) $display("FAIL conv_%0d got %h want %h", vals[i], c_bcd, exp_bcd[i]);
        else passed++;
      end
      c_out_ready = 1'b1;
      @(posedge clk); #1;
      c_out_ready = 1'b0;
    end
  endtask

  task automatic test_signed();
    logic [11:0] r; logic n_, o_; int lat;
    logic exp_neg;
    logic [11:0] exp_f6;
`ifdef BIN_TO_BCD_SIGNED_EN
    exp_neg = 1'b1;
    exp_f6  = 12'h010;
`else
    exp_neg = 1'b0;
    exp_f6  = 12'h246;
`endif
    a_run(8'h80, r, n_, o_, lat);
    checks++;
    if (r !== 12'h128 || n_ !== exp_neg || o_ !== 1'b0)
      $display("FAIL conv_0x80 got bcd=%h neg=%b ovf=%b want 128 %b 0", r, n_, o_, exp_neg);
    else passed++;
    a_run(8'hF6, r, n_, o_, lat);
    checks++;
    if (r !== exp_f6 || n_ !== exp_neg || o_ !== 1'b0)
      $display("FAIL conv_0xF6 got bcd=%h neg=%b ovf=%b want %h %b 0", r, n_, o_, exp_f6, exp_neg);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [11:0] r; logic n_, o_; int lat;
    bit seen;
    a_bin = 8'd255;
    a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0 || a_bcd !== 12'h000)
      $display("FAIL mid_reset got out_valid=%b in_ready=%b bcd=%h want 0 0 000", a_out_valid, a_in_ready, a_bcd);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (a_in_ready !== 1'b1) $display("FAIL mid_reset_release got in_ready=%b want 1", a_in_ready);
    else passed++;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (a_out_valid === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen) $display("FAIL mid_reset_discard got out_valid=1 want 0");
    else passed++;
    a_run(8'd37, r, n_, o_, lat);
    checks++;
    if (r !== 12'h037 || o_ !== 1'b0 || lat !== 8)
      $display("FAIL conv_37 got bcd=%h ovf=%b lat=%0d want 037 0 8", r, o_, lat);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_min_digits();
    test_max_8bit();
    test_back_to_back();
    test_hold_16bit();
    test_overflow();
    test_signed();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
